// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle processor control FSM (optional BNE via MULTI_CYCLE_BNE_EN)
module multi_cycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_in,
  input  logic [5:0] func_in,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_cntrl,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTI_CYCLE_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  state_t state_q;
  state_t state_d;
  logic   branch_ne;

  // Returns {legal, alu code} for an R-type function field.
  function automatic logic [4:0] r_decode(input logic [5:0] func);
    case (func)
      6'b100000: r_decode = {1'b1, ALU_ADD};
      6'b100010: r_decode = {1'b1, ALU_SUB};
      6'b100100: r_decode = {1'b1, ALU_AND};
      6'b100101: r_decode = {1'b1, ALU_OR};
      6'b101010: r_decode = {1'b1, ALU_SLT};
      default:   r_decode = {1'b0, ALU_ADD};
    endcase
  endfunction

  // State register; reset returns to FETCH from anywhere, TRAP included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

`ifdef MULTI_CYCLE_BNE_EN
  // BEQ and BNE share the BRANCH state; this flag remembers which polarity was decoded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        branch_ne <= 1'b0;
    else if (state_q == S_DECODE)   branch_ne <= (op_in == OP_BNE);
  end
`else
  assign branch_ne = 1'b0;
`endif

  // Next-state logic; opcode/function are only looked at where they steer the path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_in)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTI_CYCLE_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (func_in == 6'b000000)      state_d = S_FETCH;
            else if (r_decode(func_in)[4]) state_d = S_R_EXEC;
            else                           state_d = S_TRAP;
          end
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (op_in == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; strobes are held low while reset is asserted.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_cntrl  = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_cntrl = r_decode(func_in)[3:0];
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_cntrl = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = branch_ne ? ~zero : zero;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:   reg_write = 1'b1;
      S_TRAP:      illegal = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - randomized reference-model bench for multi_cycle_control
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op_in = '0;
  logic [5:0] func_in = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_cntrl, state;

  int checks = 0;
  int errors = 0;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADDR = 2, P_MEM_RD = 3, P_MEM_WB = 4,
                 P_MEM_WR = 5, P_R_EXEC = 6, P_R_WB = 7, P_BRANCH = 8, P_JUMP = 9,
                 P_ADDI_EXEC = 10, P_ADDI_WB = 11, P_TRAP = 12;

  multi_cycle_control dut (
    .clk(clk), .rst(rst), .op_in(op_in), .func_in(func_in), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_cntrl(alu_cntrl), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] pack(input logic pw, input logic [1:0] ps, input logic irw,
      input logic io, input logic mr, input logic mw, input logic rw, input logic rd,
      input logic m2r, input logic sa, input logic [1:0] sb, input logic [3:0] ac,
      input logic [3:0] st, input logic il);
    pack = {pw, ps, irw, io, mr, mw, rw, rd, m2r, sa, sb, ac, st, il};
  endfunction

  function automatic logic [21:0] observed();
    observed = pack(pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_cntrl, state, illegal);
  endfunction

  function automatic bit legal_func(input logic [5:0] f);
    legal_func = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
                 (f == 6'b100101) || (f == 6'b101010);
  endfunction

  function automatic logic [3:0] alu_for_func(input logic [5:0] f);
    case (f)
      6'b100010: alu_for_func = 4'b0001;
      6'b100100: alu_for_func = 4'b0010;
      6'b100101: alu_for_func = 4'b0101;
      6'b101010: alu_for_func = 4'b0100;
      default:   alu_for_func = 4'b0000;
    endcase
  endfunction

  // Expected control word for one cycle of a given phase, straight from the state table.
  function automatic logic [21:0] expect_outs(input int ph, input logic mr, input logic z,
                                              input logic [5:0] f, input bit ne);
    logic [3:0] st;
    st = 4'(ph);
    case (ph)
      P_FETCH:     expect_outs = pack(mr, 2'b00, mr, 0, 1, 0, 0, 0, 0, 0, 2'b01, 4'b0000, st, 0);
      P_DECODE:    expect_outs = pack(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, st, 0);
      P_MEM_ADDR:  expect_outs = pack(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0000, st, 0);
      P_MEM_RD:    expect_outs = pack(0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, st, 0);
      P_MEM_WB:    expect_outs = pack(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0000, st, 0);
      P_MEM_WR:    expect_outs = pack(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0000, st, 0);
      P_R_EXEC:    expect_outs = pack(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, alu_for_func(f), st, 0);
      P_R_WB:      expect_outs = pack(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0000, st, 0);
      P_BRANCH:    expect_outs = pack(ne ? ~z : z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0001, st, 0);
      P_JUMP:      expect_outs = pack(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, st, 0);
      P_ADDI_EXEC: expect_outs = pack(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0000, st, 0);
      P_ADDI_WB:   expect_outs = pack(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 4'b0000, st, 0);
      default:     expect_outs = pack(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, st, 1);
    endcase
  endfunction

  // Asserts reset mid-cycle and checks strobes/state both asynchronously and across an edge.
  task automatic do_reset(input string tag);
    logic [21:0] mask;
    mask = pack(1, 2'b00, 1, 0, 1, 1, 1, 0, 0, 0, 2'b00, 4'b0000, 4'hF, 1);
    #2 rst = 1'b1;
    #1 check({tag, "_rst_async"}, observed() & mask, 22'h0);
    @(posedge clk);
    #1 check({tag, "_rst_held"}, observed() & mask, 22'h0);
    rst = 1'b0;
  endtask

  // One cycle: drive inputs, check at the falling edge, return just after the next rising edge.
  task automatic step(input string tag, input int ph, input logic mr, input logic [5:0] op,
                      input logic [5:0] fn, input int force_z, input bit ne);
    mem_ready = mr;
    zero = (force_z >= 0) ? force_z[0] : 1'($urandom);
    if (ph == P_DECODE || ph == P_MEM_ADDR || ph == P_R_EXEC) begin
      op_in = op;
      func_in = fn;
    end else begin
      op_in = 6'($urandom);
      func_in = 6'($urandom);
    end
    @(negedge clk);
    check($sformatf("%s_ph%0d", tag, ph), observed(), expect_outs(ph, mr, zero, fn, ne));
    @(posedge clk);
    #1;
  endtask

  // Walks the phase sequence an instruction should take, starting in FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int force_wait, input int force_z, input bit abort_rd);
    int plan[$];
    bit ne;
    int nwait;
    logic mr;
    ne = 1'b0;
    plan.push_back(P_FETCH);
    plan.push_back(P_DECODE);
    case (op)
      6'b100011: begin plan.push_back(P_MEM_ADDR); plan.push_back(P_MEM_RD); plan.push_back(P_MEM_WB); end
      6'b101011: begin plan.push_back(P_MEM_ADDR); plan.push_back(P_MEM_WR); end
      6'b001000: begin plan.push_back(P_ADDI_EXEC); plan.push_back(P_ADDI_WB); end
      6'b000100: plan.push_back(P_BRANCH);
`ifdef MULTI_CYCLE_BNE_EN
      6'b000101: begin plan.push_back(P_BRANCH); ne = 1'b1; end
`endif
      6'b000010: plan.push_back(P_JUMP);
      6'b000000: begin
        if (legal_func(fn)) begin plan.push_back(P_R_EXEC); plan.push_back(P_R_WB); end
        else if (fn != 6'b000000) plan.push_back(P_TRAP);
      end
      default: plan.push_back(P_TRAP);
    endcase
    foreach (plan[i]) begin
      if (plan[i] == P_TRAP) begin
        repeat (3) step(tag, P_TRAP, 1'($urandom), op, fn, force_z, ne);
        do_reset(tag);
        return;
      end
      nwait = 0;
      if (plan[i] == P_FETCH || plan[i] == P_MEM_RD || plan[i] == P_MEM_WR)
        nwait = (force_wait >= 0) ? force_wait :
                (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      for (int c = 0; c <= nwait; c++) begin
        if (plan[i] == P_FETCH || plan[i] == P_MEM_RD || plan[i] == P_MEM_WR)
          mr = (c < nwait) ? 1'b0 : 1'b1;
        else
          mr = 1'($urandom);
        step(tag, plan[i], mr, op, fn, force_z, ne);
        if (abort_rd && plan[i] == P_MEM_RD && mr == 1'b0) begin
          do_reset(tag);
          return;
        end
      end
    end
  endtask

  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    int sel;
    do_reset("init");

    run_instr("lw_ready", 6'b100011, 6'h00, 0, -1, 0);
    run_instr("sw_wait3", 6'b101011, 6'h00, 3, -1, 0);
    run_instr("beq_z1", 6'b000100, 6'h00, 0, 1, 0);
    run_instr("beq_z0", 6'b000100, 6'h00, 0, 0, 0);
    run_instr("r_slt", 6'b000000, 6'b101010, 0, -1, 0);
    run_instr("nop", 6'b000000, 6'b000000, 0, -1, 0);
    run_instr("jump", 6'b000010, 6'h00, 0, -1, 0);
    run_instr("addi", 6'b001000, 6'h00, 1, -1, 0);
    run_instr("bad_func", 6'b000000, 6'b000111, 0, -1, 0);
    run_instr("bne_z0", 6'b000101, 6'h00, 0, 0, 0);
    run_instr("bne_z1", 6'b000101, 6'h00, 0, 1, 0);
    run_instr("lw_abort", 6'b100011, 6'h00, 2, -1, 1);
    run_instr("after_abort", 6'b100011, 6'h00, 1, -1, 0);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 19);
      rfn = 6'($urandom);
      case (sel)
        0, 1, 2:  rop = 6'b100011;
        3, 4, 5:  rop = 6'b101011;
        6, 7, 8:  begin
          rop = 6'b000000;
          case ($urandom_range(0, 4))
            0: rfn = 6'b100000;
            1: rfn = 6'b100010;
            2: rfn = 6'b100100;
            3: rfn = 6'b100101;
            default: rfn = 6'b101010;
          endcase
        end
        9, 10:    rop = 6'b001000;
        11, 12:   rop = 6'b000100;
        13, 14:   rop = 6'b000010;
        15:       begin rop = 6'b000000; rfn = 6'b000000; end
        16:       rop = 6'b000101;
        17:       begin
          rop = 6'b000000;
          while (legal_func(rfn) || rfn == 6'b000000) rfn = 6'($urandom);
        end
        18:       begin
          rop = 6'($urandom);
          while (rop == 6'b100011 || rop == 6'b101011 || rop == 6'b001000 ||
                 rop == 6'b000100 || rop == 6'b000010 || rop == 6'b000000 ||
                 rop == 6'b000101)
            rop = 6'($urandom);
        end
        default:  rop = 6'b100011;
      endcase
      run_instr($sformatf("rnd%0d", n), rop, rfn, -1, -1, (sel == 19));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
